edge_event_detector: RTL and testbench

Multi-channel, parametrised edge detector with per-channel rising/falling/both-edge modes and optional input synchronisers. Qualifying edges accumulate in per-channel saturating counters that are drained one channel at a time through a round-robin val/rdy response port. The block sits between raw asynchronous status lines (async FIFO flags, external strobes) and a single consumer that must not lose or merge events from different channels.

---
 rtl/edge_event_detector.sv | 123 ++++++++++++
 tb/tb_edge_event_detector.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_detector.sv
// rtl/edge_event_detector.sv - multi-channel edge detector with saturating counters
// and a round-robin val/rdy drain port.
module edge_event_detector #(
  parameter int p_num_chans   = 4,
  parameter int p_sync_stages = 2,
  parameter int p_cnt_width   = 8,
  localparam int p_chan_width = (p_num_chans > 1) ? $clog2(p_num_chans) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p_num_chans-1:0]     req_sig,
  input  logic [2*p_num_chans-1:0]   mode,
  output logic [p_num_chans-1:0]     edge_pulse,
  output logic                       resp_val,
  input  logic                       resp_rdy,
  output logic [p_chan_width-1:0]    resp_chan,
  output logic [p_cnt_width-1:0]     resp_count,
  output logic                       resp_ovf
);

  localparam logic [p_chan_width-1:0] last_chan = p_chan_width'(p_num_chans - 1);

  logic [p_num_chans-1:0] s;
  logic [p_num_chans-1:0] prev;
  logic [p_num_chans-1:0] rise;
  logic [p_num_chans-1:0] fall;
  logic [p_cnt_width-1:0] cnt [p_num_chans];
  logic [p_num_chans-1:0] ovf;
  logic [p_chan_width-1:0] rr_ptr;
  logic [p_chan_width-1:0] sel;
  logic [p_chan_width-1:0] rr_next;
  logic                    found;
  logic                    load;
  logic                    take;

  generate
    if (p_sync_stages == 0) begin : g_nosync
      assign s = req_sig;
    end else begin : g_sync
      logic [p_num_chans-1:0] sync_q [p_sync_stages];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < p_sync_stages; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= req_sig;
          for (int k = 1; k < p_sync_stages; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[p_sync_stages-1];
    end
  endgenerate

  assign rise = s & ~prev;
  assign fall = ~s & prev;

  always_comb begin
    edge_pulse = '0;
    for (int i = 0; i < p_num_chans; i++)
      edge_pulse[i] = (mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]);
  end

  // First non-empty channel at or after rr_ptr, wrapping.
  always_comb begin
    int idx_i;
    logic [p_chan_width-1:0] idx;
    found = 1'b0;
    sel   = '0;
    idx_i = 0;
    idx   = '0;
    for (int k = 0; k < p_num_chans; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= p_num_chans) idx_i = idx_i - p_num_chans;
      idx = idx_i[p_chan_width-1:0];
      if (!found && cnt[idx] != '0) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign rr_next = (sel == last_chan) ? '0 : sel + 1'b1;
  assign load    = !resp_val || resp_rdy;
  assign take    = load && found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= '0;
      ovf  <= '0;
      for (int i = 0; i < p_num_chans; i++) cnt[i] <= '0;
    end else begin
      prev <= s;
      for (int i = 0; i < p_num_chans; i++) begin
        // A pulse coinciding with the drain restarts the count at one.
        if (take && sel == p_chan_width'(i)) begin
          cnt[i] <= edge_pulse[i] ? p_cnt_width'(1) : '0;
          ovf[i] <= 1'b0;
        end else if (edge_pulse[i]) begin
          if (&cnt[i]) ovf[i] <= 1'b1;
          else         cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_val   <= 1'b0;
      resp_chan  <= '0;
      resp_count <= '0;
      resp_ovf   <= 1'b0;
      rr_ptr     <= '0;
    end else if (load) begin
      resp_val <= found;
      if (found) begin
        resp_chan  <= sel;
        resp_count <= cnt[sel];
        resp_ovf   <= ovf[sel];
        rr_ptr     <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_detector.sv
// tb/tb_edge_event_detector.sv - directed self-checking bench for edge_event_detector.
module tb_edge_event_detector;

  logic       clk;
  logic       reset;
  logic [3:0] req_sig;
  logic [7:0] mode;
  logic       resp_rdy;
  logic [3:0] edge_pulse;
  logic       resp_val;
  logic [1:0] resp_chan;
  logic [7:0] resp_count;
  logic       resp_ovf;

  logic [3:0] req_sig_b;
  logic [7:0] mode_b;
  logic       rdy_b;
  logic [3:0] edge_pulse_b;
  logic       val_b;
  logic [1:0] chan_b;
  logic [1:0] count_b;
  logic       ovf_b;

  int checks;
  int errors;

  edge_event_detector #(.p_num_chans(4), .p_sync_stages(2), .p_cnt_width(8)) dut_a (
    .clk(clk), .reset(reset), .req_sig(req_sig), .mode(mode),
    .edge_pulse(edge_pulse), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_chan(resp_chan), .resp_count(resp_count), .resp_ovf(resp_ovf)
  );

  edge_event_detector #(.p_num_chans(4), .p_sync_stages(2), .p_cnt_width(2)) dut_b (
    .clk(clk), .reset(reset), .req_sig(req_sig_b), .mode(mode_b),
    .edge_pulse(edge_pulse_b), .resp_val(val_b), .resp_rdy(rdy_b),
    .resp_chan(chan_b), .resp_count(count_b), .resp_ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    int pulses;
    reset = 1'b0; req_sig = 4'b0001; mode = 8'b0000_0001; resp_rdy = 1'b0;
    req_sig_b = '0; mode_b = '0; rdy_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({edge_pulse, resp_val, resp_chan, resp_count, resp_ovf} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {edge_pulse, resp_val, resp_chan, resp_count, resp_ovf});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (edge_pulse !== 4'b0000) begin
      errors++; $display("FAIL reset_pulse_e0 got %b want 0000", edge_pulse);
    end
    @(negedge clk);
    checks++;
    if (edge_pulse !== 4'b0001) begin
      errors++; $display("FAIL reset_pulse_e1 got %b want 0001", edge_pulse);
    end
    @(negedge clk);
    checks++;
    if (resp_val !== 1'b0) begin
      errors++; $display("FAIL reset_val_e2 got %b want 0", resp_val);
    end
    @(negedge clk);
    checks++;
    if ({resp_val, resp_chan, resp_count, resp_ovf} !== {1'b1, 2'd0, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_record got val %b chan %0d cnt %0d ovf %b want 1 0 1 0",
               resp_val, resp_chan, resp_count, resp_ovf);
    end
    resp_rdy = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(edge_pulse[0]);
    end
    checks++;
    if (pulses != 0 || resp_val !== 1'b0) begin
      errors++; $display("FAIL reset_no_more got pulses %0d val %b want 0 0", pulses, resp_val);
    end
    mode = '0; req_sig = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_toggle_stall();
    resp_rdy = 1'b0;
    mode = 8'b0000_1100;
    for (int t = 0; t < 5; t++) begin
      req_sig[1] = ~req_sig[1];
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    checks++;
    if ({resp_val, resp_chan, resp_count, resp_ovf} !== {1'b1, 2'd1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL toggle_first got val %b chan %0d cnt %0d ovf %b want 1 1 1 0",
               resp_val, resp_chan, resp_count, resp_ovf);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({resp_val, resp_chan, resp_count, resp_ovf} !== {1'b1, 2'd1, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL toggle_second got val %b chan %0d cnt %0d ovf %b want 1 1 4 0",
               resp_val, resp_chan, resp_count, resp_ovf);
    end
    @(negedge clk);
    checks++;
    if (resp_val !== 1'b0) begin
      errors++; $display("FAIL toggle_drained got %b want 0", resp_val);
    end
    mode = '0; req_sig = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_saturation();
    rdy_b = 1'b0;
    mode_b = 8'b0001_0000;
    for (int t = 0; t < 6; t++) begin
      req_sig_b[2] = 1'b1;
      @(negedge clk);
      req_sig_b[2] = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({val_b, chan_b, count_b, ovf_b} !== {1'b1, 2'd2, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL sat_first got val %b chan %0d cnt %0d ovf %b want 1 2 1 0", val_b, chan_b, count_b, ovf_b);
    end
    rdy_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({val_b, chan_b, count_b, ovf_b} !== {1'b1, 2'd2, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL sat_second got val %b chan %0d cnt %0d ovf %b want 1 2 3 1", val_b, chan_b, count_b, ovf_b);
    end
    @(negedge clk);
    checks++;
    if (val_b !== 1'b0) begin
      errors++; $display("FAIL sat_drained got %b want 0", val_b);
    end
    rdy_b = 1'b0;
    req_sig_b[2] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({val_b, chan_b, count_b, ovf_b} !== {1'b1, 2'd2, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL sat_ovf_cleared got val %b chan %0d cnt %0d ovf %b want 1 2 1 0", val_b, chan_b, count_b, ovf_b);
    end
    rdy_b = 1'b1;
    mode_b = '0; req_sig_b = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_round_robin();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    resp_rdy = 1'b1;
    mode = 8'b0100_0101;
    req_sig = 4'b1011;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [1:0] want;
      @(negedge clk);
      want = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : 2'd3;
      checks++;
      if ({resp_val, resp_chan, resp_count} !== {1'b1, want, 8'd1}) begin
        errors++;
        $display("FAIL rr_simul_%0d got val %b chan %0d cnt %0d want 1 %0d 1", k, resp_val, resp_chan, resp_count, want);
      end
    end
    @(negedge clk);
    checks++;
    if (resp_val !== 1'b0) begin
      errors++; $display("FAIL rr_simul_drained got %b want 0", resp_val);
    end
    req_sig = 4'b0000;
    repeat (4) @(negedge clk);
    req_sig = 4'b1010;
    @(negedge clk);
    req_sig[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [1:0] want;
      @(negedge clk);
      want = (k == 0) ? 2'd1 : (k == 1) ? 2'd3 : 2'd0;
      checks++;
      if ({resp_val, resp_chan} !== {1'b1, want}) begin
        errors++;
        $display("FAIL rr_order_%0d got val %b chan %0d want 1 %0d", k, resp_val, resp_chan, want);
      end
    end
    mode = '0; req_sig = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_same_cycle();
    resp_rdy = 1'b1;
    mode = 8'b0011_0000;
    req_sig[2] = 1'b1;
    @(negedge clk);
    req_sig[2] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({resp_val, resp_chan, resp_count, resp_ovf} !== {1'b1, 2'd2, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL same_first got val %b chan %0d cnt %0d ovf %b want 1 2 1 0",
               resp_val, resp_chan, resp_count, resp_ovf);
    end
    @(negedge clk);
    checks++;
    if ({resp_val, resp_chan, resp_count, resp_ovf} !== {1'b1, 2'd2, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL same_second got val %b chan %0d cnt %0d ovf %b want 1 2 1 0",
               resp_val, resp_chan, resp_count, resp_ovf);
    end
    @(negedge clk);
    checks++;
    if (resp_val !== 1'b0) begin
      errors++; $display("FAIL same_drained got %b want 0", resp_val);
    end
    mode = '0; req_sig = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    resp_rdy = 1'b0;
    mode = 8'b0101_0101;
    req_sig = 4'b1111;
    repeat (6) @(negedge clk);
    checks++;
    if (resp_val !== 1'b1) begin
      errors++; $display("FAIL midop_pending got val %b want 1", resp_val);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({edge_pulse, resp_val, resp_chan, resp_count, resp_ovf} !== 16'h0) begin
      errors++;
      $display("FAIL midop_async_clear got %h want 0", {edge_pulse, resp_val, resp_chan, resp_count, resp_ovf});
    end
    req_sig = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    resp_rdy = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if ({resp_val, edge_pulse, val_b} !== 6'b0) begin
      errors++;
      $display("FAIL midop_no_records got val %b pulse %b val_b %b want 0", resp_val, edge_pulse, val_b);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_toggle_stall();
    test_saturation();
    test_round_robin();
    test_same_cycle();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
